// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned VOTE_T0    = 7;
    localparam int unsigned VOTE_T1    = 8;
    localparam int unsigned VOTE_T2    = 9;

    function automatic int unsigned tick_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO: push/pop with registered head output and occupancy count.
// A push while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               din,
    input  logic                           pop,
    output logic [WIDTH-1:0]               dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nx;
    logic             wr_en;
    logic             rd_en;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign rd_en     = pop & ~empty;
    assign wr_en     = push & (~full | rd_en);
    assign rd_ptr_nx = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr_nx;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Head register: a byte written into the slot that becomes head bypasses memory.
            if (wr_en && empty) begin
                dout <= din;
            end else if (rd_en) begin
                if (count == CW'(1)) begin
                    if (wr_en)
                        dout <= din;
                end else begin
                    dout <= mem[rd_ptr_nx];
                end
            end
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 16x oversampled UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a small FIFO.
// Bits are majority-voted at oversample ticks 7/8/9 of each bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rx,
    input  logic                              rd,
    output logic [7:0]                        data,
    output logic                              valid,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              frame_err,
    output logic                              overrun,
    output logic                              parity_err
);

    localparam int unsigned TICK_DIV = tick_div(CLK_HZ, BAUD);
    localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned OS_W     = $clog2(OVERSAMPLE);

    logic             rx_meta;
    logic             rxs;
    uart_rx_state_t   state;
    logic [DIV_W-1:0] div_cnt;
    logic [OS_W-1:0]  os_cnt;
    logic [OS_W-1:0]  os_next;
    logic [1:0]       votes;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             push_q;
    logic             in_frame;
    logic             tick;
    logic             vote_now;
    logic             voted;
    logic             pop;
    logic             full;
    logic             empty;
`ifdef UART_RX_PARITY_EN
    logic             par_bad;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign in_frame = (state != ST_IDLE) && (state != ST_BREAK);
    assign tick     = (div_cnt == DIV_W'(TICK_DIV - 1));
    assign os_next  = os_cnt + 1'b1;
    assign vote_now = in_frame && tick && (os_next == OS_W'(VOTE_T2));
    assign voted    = (votes[0] & votes[1]) | (votes[0] & rxs) | (votes[1] & rxs);
    assign pop      = rd & ~empty;
    assign valid    = ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            os_cnt    <= '0;
            votes     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            push_q    <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= push_q & full & ~pop;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (!in_frame || tick)
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;

            // The sub-bit counter free-runs mod 16 across bits; each state decides on vote tick 9.
            if (in_frame && tick) begin
                os_cnt <= os_next;
                if (os_next == OS_W'(VOTE_T0))
                    votes[0] <= rxs;
                if (os_next == OS_W'(VOTE_T1))
                    votes[1] <= rxs;
            end

            case (state)
                ST_IDLE: begin
                    os_cnt <= '0;
                    if (!rxs)
                        state <= ST_START;
                end
                ST_START: begin
                    if (vote_now) begin
                        if (voted) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (vote_now) begin
                        shift   <= {voted, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (vote_now) begin
                        par_bad <= voted ^ (^shift);
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (vote_now) begin
                        if (!voted) begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            parity_err <= 1'b1;
                            state      <= ST_IDLE;
`endif
                        end else begin
                            push_q <= 1'b1;
                            state  <= ST_IDLE;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rxs)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .din   (shift),
        .pop   (pop),
        .dout  (data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: serial frames driven from a bit-level model,
// received bytes checked against a queue model of the receive buffer.
module tb_uart_receiver;

    localparam int unsigned CLK_HZ = 50000000;
    localparam int unsigned BAUD   = 115200;
    localparam int unsigned DEPTH  = 8;
    localparam int TD  = CLK_HZ / (BAUD * 16);
`ifdef UART_RX_PARITY_EN
    localparam int NB  = 11;
`else
    localparam int NB  = 10;
`endif
    localparam int BIT = TD * 16;
    // Line fall to valid visible: 2 sync + 1 FSM + stop-bit tick 9 + push register.
    localparam int LAT = 3 + ((NB - 1) * 16 + 9) * TD + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic [3:0] count;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int rise_cyc = 0;
    logic valid_d = 1'b0;
    logic [7:0] q[$];

    uart_receiver #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd         (rd),
        .data       (data),
        .valid      (valid),
        .count      (count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err)  fe_cnt = fe_cnt + 1;
        if (overrun)    ov_cnt = ov_cnt + 1;
        if (parity_err) pe_cnt = pe_cnt + 1;
        if (valid && !valid_d) rise_cyc = cyc;
        valid_d = valid;
    end

    function automatic logic [15:0] frame(input logic [7:0] b, input logic par, input logic stop);
        logic [15:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = b;
        if (NB == 11) f[9] = par;
        f[NB-1] = stop;
        return f;
    endfunction

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx = bits[i];
            repeat (BIT) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b);
        send_bits(frame(b, ^b, 1'b1), NB);
    endtask

    task automatic pop_one();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
        tests++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", data); end
        tests++; if ({frame_err, overrun, parity_err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {frame_err, overrun, parity_err}); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single(input logic [7:0] b);
        int c0;
        int lat;
        c0 = cyc;
        send_frame(b);
        q.push_back(b);
        lat = rise_cyc - c0;
        tests++; if (lat < LAT - 2 || lat > LAT + 2) begin fails++; $display("FAIL single_latency: got %0d expected %0d", lat, LAT); end
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", valid); end
        tests++; if (data !== q[0]) begin fails++; $display("FAIL single_data: got %h expected %h", data, q[0]); end
        tests++; if (count !== 4'(q.size())) begin fails++; $display("FAIL single_count: got %0d expected %0d", count, q.size()); end
        pop_one();
        void'(q.pop_front());
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL single_pop_valid: got %b expected 0", valid); end
        tests++; if (count !== 4'(q.size())) begin fails++; $display("FAIL single_pop_count: got %0d expected %0d", count, q.size()); end
    endtask

    task automatic test_overrun();
        int ov0;
        int exp_ov;
        ov0 = ov_cnt;
        exp_ov = 0;
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i));
            if (q.size() < DEPTH) q.push_back(8'(i));
            else exp_ov++;
        end
        tests++; if (ov_cnt - ov0 !== exp_ov) begin fails++; $display("FAIL overrun_pulses: got %0d expected %0d", ov_cnt - ov0, exp_ov); end
        tests++; if (count !== 4'(q.size())) begin fails++; $display("FAIL overrun_count: got %0d expected %0d", count, q.size()); end
        tests++; if (data !== q[0]) begin fails++; $display("FAIL overrun_head: got %h expected %h", data, q[0]); end
    endtask

    task automatic test_full_pop();
        int ov0;
        logic [7:0] b;
        logic [7:0] exp;
        ov0 = ov_cnt;
        b = 8'($urandom);
        fork
            send_frame(b);
            begin
                repeat (LAT - 1) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        void'(q.pop_front());
        q.push_back(b);
        tests++; if (ov_cnt - ov0 !== 0) begin fails++; $display("FAIL fullpop_overrun: got %0d expected 0", ov_cnt - ov0); end
        tests++; if (count !== 4'(q.size())) begin fails++; $display("FAIL fullpop_count: got %0d expected %0d", count, q.size()); end
        for (int i = 0; i < DEPTH; i++) begin
            exp = q.pop_front();
            tests++; if (valid !== 1'b1 || data !== exp) begin fails++; $display("FAIL fullpop_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, valid, data, exp); end
            pop_one();
        end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL fullpop_empty: got %b expected 0", valid); end
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_cnt;
        send_bits(frame(8'hA5, ^8'hA5, 1'b0), NB);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cnt - fe0); end
        tests++; if (count !== 4'(q.size())) begin fails++; $display("FAIL ferr_no_push: got %0d expected %0d", count, q.size()); end
        send_frame(8'h3C);
        q.push_back(8'h3C);
        tests++; if (valid !== 1'b1 || data !== 8'h3C) begin fails++; $display("FAIL ferr_recover: got valid=%b data=%h expected valid=1 data=3c", valid, data); end
        tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL ferr_recover_flag: got %0d expected 1", fe_cnt - fe0); end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_cnt;
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL glitch_ferr: got %0d expected 0", fe_cnt - fe0); end
        tests++; if (count !== 4'(q.size()) || data !== q[0]) begin fails++; $display("FAIL glitch_fifo: got count=%0d data=%h expected count=%0d data=%h", count, data, q.size(), q[0]); end
    endtask

    task automatic test_reset_mid();
        int fe0;
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        q.delete();
        tests++; if (valid !== 1'b0 || count !== 4'd0 || data !== 8'h00) begin fails++; $display("FAIL midreset_fifo: got valid=%b count=%0d data=%h expected 0/0/00", valid, count, data); end
        tests++; if ({frame_err, overrun, parity_err} !== 3'b000) begin fails++; $display("FAIL midreset_flags: got %b expected 000", {frame_err, overrun, parity_err}); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (8 * BIT) @(negedge clk);
        tests++; if (count !== 4'd0) begin fails++; $display("FAIL midreset_no_partial: got %0d expected 0", count); end
        fe0 = fe_cnt;
        send_frame(8'h12);
        q.push_back(8'h12);
        tests++; if (valid !== 1'b1 || data !== 8'h12 || count !== 4'(q.size())) begin fails++; $display("FAIL midreset_next: got valid=%b data=%h count=%0d expected 1/12/%0d", valid, data, count, q.size()); end
        tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL midreset_ferr: got %0d expected 0", fe_cnt - fe0); end
        pop_one();
        void'(q.pop_front());
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        int pe0;
        pe0 = pe_cnt;
        send_bits(frame(8'h03, 1'b1, 1'b1), NB);
        repeat (BIT) @(negedge clk);
        tests++; if (pe_cnt - pe0 !== 1) begin fails++; $display("FAIL parity_bad_pulse: got %0d expected 1", pe_cnt - pe0); end
        tests++; if (count !== 4'(q.size())) begin fails++; $display("FAIL parity_bad_push: got %0d expected %0d", count, q.size()); end
        send_bits(frame(8'h03, 1'b0, 1'b1), NB);
        q.push_back(8'h03);
        tests++; if (valid !== 1'b1 || data !== 8'h03) begin fails++; $display("FAIL parity_good: got valid=%b data=%h expected 1/03", valid, data); end
        tests++; if (pe_cnt - pe0 !== 1) begin fails++; $display("FAIL parity_good_flag: got %0d expected 1", pe_cnt - pe0); end
        pop_one();
        void'(q.pop_front());
`else
        tests++; if (pe_cnt !== 0) begin fails++; $display("FAIL parity_tied: got %0d pulses expected 0", pe_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_single(8'h55);
        test_single(8'($urandom));
        test_overrun();
        test_full_pop();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
